// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for Execute: radix-2 iterative divide (and multiply when MUL_SINGLE=0).
// Fast paths finish in the start cycle; iterative ops hold BusyE XLEN+1 cycles, DoneE in the cycle after that.
module muldiv_sequencer #(
  parameter int XLEN       = 32,
  parameter bit MUL_SINGLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic [2:0]      MulDivCtrlE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            AbortE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] MulDivResultE
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, nextState;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] opnd;
  logic [2:0]      opReg;
  logic            negReg;

  logic            isDiv, signedA, signedB, sA, sB, negStart;
  logic            divZero, ovf, fastPath, startIter;
  logic [XLEN-1:0] magA, magB, fastRes, doneRes;
  logic [2*XLEN-1:0] prodMag, prodFix, mulProd, accNext;
  logic [XLEN:0]   divTrial, mulSum;
  logic [XLEN-1:0] quo, rem;

  // Operand decode at start: signedness, magnitudes, result sign.
  always_comb begin
    isDiv   = MulDivCtrlE[2];
    signedA = 1'b0;
    signedB = 1'b0;
    case (MulDivCtrlE)
      3'd0, 3'd1, 3'd4, 3'd6: begin signedA = 1'b1; signedB = 1'b1; end
      3'd2:                   signedA = 1'b1;
      default:                ;
    endcase
    sA   = signedA & SrcAE[XLEN-1];
    sB   = signedB & SrcBE[XLEN-1];
    magA = sA ? (~SrcAE + 1'b1) : SrcAE;
    magB = sB ? (~SrcBE + 1'b1) : SrcBE;
    case (MulDivCtrlE)
      3'd0, 3'd1, 3'd4: negStart = sA ^ sB;
      3'd2, 3'd6:       negStart = sA;
      default:          negStart = 1'b0;
    endcase
    divZero   = isDiv && (SrcBE == '0);
    ovf       = (MulDivCtrlE == 3'd4 || MulDivCtrlE == 3'd6) && (SrcAE == MIN_NEG) && (&SrcBE);
    fastPath  = (!isDiv && MUL_SINGLE) || divZero || ovf;
    startIter = (state == IDLE) && StartE && !AbortE && !fastPath;
  end

  always_comb begin
    prodMag = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
    prodFix = negStart ? (~prodMag + 1'b1) : prodMag;
    if (divZero)
      fastRes = MulDivCtrlE[1] ? SrcAE : '1;
    else if (ovf)
      fastRes = MulDivCtrlE[1] ? '0 : MIN_NEG;
    else if (MulDivCtrlE == 3'd0)
      fastRes = prodFix[XLEN-1:0];
    else
      fastRes = prodFix[2*XLEN-1:XLEN];
  end

  // acc holds {remainder, quotient} for divide, {partial product, multiplier} for multiply.
  always_comb begin
    divTrial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    if (opReg[2]) begin
      if (divTrial[XLEN])
        accNext = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
      else
        accNext = {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      accNext = {mulSum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    mulProd = negReg ? (~acc + 1'b1) : acc;
    quo     = acc[XLEN-1:0];
    rem     = acc[2*XLEN-1:XLEN];
    case (opReg)
      3'd0:             doneRes = mulProd[XLEN-1:0];
      3'd1, 3'd2, 3'd3: doneRes = mulProd[2*XLEN-1:XLEN];
      3'd4, 3'd5:       doneRes = negReg ? (~quo + 1'b1) : quo;
      default:          doneRes = negReg ? (~rem + 1'b1) : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startIter) nextState = RUN;
      RUN:     if (AbortE) nextState = IDLE;
               else if (cnt == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, even if StartE is held.
  always_comb begin
    BusyE         = 1'b0;
    DoneE         = 1'b0;
    MulDivResultE = '0;
    if (rst_n) begin
      case (state)
        IDLE: if (StartE && !AbortE) begin
          if (fastPath) begin
            DoneE         = 1'b1;
            MulDivResultE = fastRes;
          end else begin
            BusyE = 1'b1;
          end
        end
        RUN:  BusyE = 1'b1;
        DONE: if (!AbortE) begin
          DoneE         = 1'b1;
          MulDivResultE = doneRes;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      opReg  <= '0;
      negReg <= 1'b0;
    end else if (startIter) begin
      cnt    <= CW'(XLEN-1);
      opReg  <= MulDivCtrlE;
      negReg <= negStart;
      if (isDiv) begin
        acc  <= {{XLEN{1'b0}}, magA};
        opnd <= magB;
      end else begin
        acc  <= {{XLEN{1'b0}}, magB};
        opnd <= magA;
      end
    end else if (state == RUN) begin
      acc <= accNext;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule
